fnv_1a_stream: RTL and testbench

Parametrised, byte-streaming FNV-1a hash engine with framed messages and a valid/ready input handshake. Hash width is a parameter (32 or 64 bits). The multiply by the FNV prime is iterative, one prime byte per cycle, to keep area small. It sits behind the I2C peripheral's byte receive path and produces a hash of each framed message for register readback.

---
 rtl/fnv_1a_stream_if.sv | 38 +++
 rtl/fnv_1a_stream.sv | 152 +++++++++++++++
 tb/tb_fnv_1a_stream.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fnv_1a_stream_if.sv
// -----------------------------------------------------------------------------
// fnv_1a_stream_if
//   Byte-stream and result bundle for the fnv_1a_stream hash engine.
//
//   Signals:
//     clear       producer -> engine   synchronous abort of any open message
//     in_data     producer -> engine   message byte
//     in_last     producer -> engine   final byte of the message
//     in_valid    producer -> engine   byte present
//     in_ready    engine -> producer   engine can accept a byte this cycle
//     busy        engine -> producer   multiply in progress
//     hash_valid  engine -> producer   hash_out holds the latest completed hash
//     hash_out    engine -> producer   result register (HASH_WIDTH bits)
//
//   Modports: master = byte producer / register reader, slave = hash engine.
// -----------------------------------------------------------------------------
interface fnv_1a_stream_if #(
  parameter int HASH_WIDTH = 32
);
  logic                  clear;
  logic [7:0]            in_data;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic                  busy;
  logic                  hash_valid;
  logic [HASH_WIDTH-1:0] hash_out;

  modport master (
    output clear, in_data, in_last, in_valid,
    input  in_ready, busy, hash_valid, hash_out
  );

  modport slave (
    input  clear, in_data, in_last, in_valid,
    output in_ready, busy, hash_valid, hash_out
  );
endinterface

// File: rtl/fnv_1a_stream.sv
// -----------------------------------------------------------------------------
// fnv_1a_stream
//   Byte-streaming FNV-1a hash engine for framed messages. Each accepted byte
//   is XORed into the running hash, then multiplied by the FNV prime one prime
//   byte per cycle (HASH_WIDTH/8 cycles per byte). The byte flagged in_last
//   closes the message and publishes the hash on hash_out / hash_valid.
//
//   Parameters:
//     HASH_WIDTH    32 or 64
//     OFFSET_BASIS  initial hash value (HASH_WIDTH bits)
//     FNV_PRIME     multiplier (HASH_WIDTH bits)
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; clears all state
//     bus    fnv_1a_stream_if slave modport (byte stream in, hash out)
// -----------------------------------------------------------------------------
module fnv_1a_stream #(
  parameter int                    HASH_WIDTH   = 32,
  parameter logic [HASH_WIDTH-1:0] OFFSET_BASIS = 32'd2166136261,
  parameter logic [HASH_WIDTH-1:0] FNV_PRIME    = 32'd16777619
) (
  input  logic           clk,
  input  logic           reset,
  fnv_1a_stream_if.slave bus
);

  localparam int STEPS = HASH_WIDTH / 8;
  localparam int KW    = $clog2(STEPS);

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } fsm_t;

  fsm_t                  fsm_reg,        fsm_next;
  logic [HASH_WIDTH-1:0] hash_state_reg, hash_state_next;
  logic [HASH_WIDTH-1:0] op_reg,         op_next;
  logic [HASH_WIDTH-1:0] acc_reg,        acc_next;
  logic [HASH_WIDTH-1:0] hash_out_reg,   hash_out_next;
  logic [KW-1:0]         k_reg,          k_next;
  logic                  open_reg,       open_next;
  logic                  last_q_reg,     last_q_next;
  logic                  hash_valid_reg, hash_valid_next;

  // Prime split into bytes; step k multiplies by byte k.
  logic [7:0] prime_byte [STEPS];

  generate
    for (genvar gi = 0; gi < STEPS; gi++) begin : g_prime
      assign prime_byte[gi] = FNV_PRIME[8*gi +: 8];
    end
  endgenerate

  // One step of the shift-and-add multiply. The product is truncated to
  // HASH_WIDTH before the shift, which gives the same low bits as shifting
  // the full W+8-bit partial product and truncating afterwards.
  logic [HASH_WIDTH-1:0] partial;
  logic [HASH_WIDTH-1:0] shifted;
  logic [HASH_WIDTH-1:0] acc_sum;
  logic                  last_step;

  assign partial   = op_reg * HASH_WIDTH'(prime_byte[k_reg]);
  assign shifted   = partial << {k_reg, 3'b000};
  assign acc_sum   = acc_reg + shifted;
  assign last_step = (k_reg == KW'(STEPS - 1));

  // Handshake outputs come straight from registered state only.
  assign bus.in_ready   = (fsm_reg == IDLE);
  assign bus.busy       = (fsm_reg == MUL);
  assign bus.hash_valid = hash_valid_reg;
  assign bus.hash_out   = hash_out_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_reg        <= IDLE;
      hash_state_reg <= OFFSET_BASIS;
      op_reg         <= '0;
      acc_reg        <= '0;
      hash_out_reg   <= '0;
      k_reg          <= '0;
      open_reg       <= 1'b0;
      last_q_reg     <= 1'b0;
      hash_valid_reg <= 1'b0;
    end else begin
      fsm_reg        <= fsm_next;
      hash_state_reg <= hash_state_next;
      op_reg         <= op_next;
      acc_reg        <= acc_next;
      hash_out_reg   <= hash_out_next;
      k_reg          <= k_next;
      open_reg       <= open_next;
      last_q_reg     <= last_q_next;
      hash_valid_reg <= hash_valid_next;
    end
  end

  always_comb begin
    fsm_next        = fsm_reg;
    hash_state_next = hash_state_reg;
    op_next         = op_reg;
    acc_next        = acc_reg;
    hash_out_next   = hash_out_reg;
    k_next          = k_reg;
    open_next       = open_reg;
    last_q_next     = last_q_reg;
    hash_valid_next = hash_valid_reg;

    if (bus.clear) begin
      // Abort wins over the handshake: a byte offered now is dropped and any
      // partial product is discarded. hash_out keeps its last value.
      fsm_next        = IDLE;
      open_next       = 1'b0;
      hash_valid_next = 1'b0;
      k_next          = '0;
    end else begin
      unique case (fsm_reg)
        IDLE: begin
          if (bus.in_valid) begin
            // First byte of a message starts from the basis, not the
            // previous message's hash.
            op_next         = (open_reg ? hash_state_reg : OFFSET_BASIS)
                              ^ HASH_WIDTH'(bus.in_data);
            acc_next        = '0;
            k_next          = '0;
            last_q_next     = bus.in_last;
            hash_valid_next = 1'b0;
            fsm_next        = MUL;
          end
        end
        MUL: begin
          acc_next = acc_sum;
          k_next   = k_reg + KW'(1);
          if (last_step) begin
            hash_state_next = acc_sum;
            k_next          = '0;
            fsm_next        = IDLE;
            if (last_q_reg) begin
              hash_out_next   = acc_sum;
              hash_valid_next = 1'b1;
              open_next       = 1'b0;
            end else begin
              open_next       = 1'b1;
            end
          end
        end
        default: fsm_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fnv_1a_stream.sv
// -----------------------------------------------------------------------------
// tb_fnv_1a_stream
//   Self-checking bench for fnv_1a_stream. One 32-bit and one 64-bit instance
//   share clock and reset. Known-answer vectors come from a table; abort and
//   asynchronous reset are hand-written sequences; random streams are checked
//   against a plain-arithmetic FNV-1a model and a cycle-count model of the
//   handshake.
// -----------------------------------------------------------------------------
module tb_fnv_1a_stream;

  logic clk;
  logic reset;
  int   cyc;
  int   n_vec;
  int   n_bad;

  fnv_1a_stream_if #(.HASH_WIDTH(32)) if32 ();
  fnv_1a_stream_if #(.HASH_WIDTH(64)) if64 ();

  fnv_1a_stream #(
    .HASH_WIDTH  (32),
    .OFFSET_BASIS(32'd2166136261),
    .FNV_PRIME   (32'd16777619)
  ) dut32 (
    .clk  (clk),
    .reset(reset),
    .bus  (if32)
  );

  fnv_1a_stream #(
    .HASH_WIDTH  (64),
    .OFFSET_BASIS(64'hcbf29ce484222325),
    .FNV_PRIME   (64'h00000100000001b3)
  ) dut64 (
    .clk  (clk),
    .reset(reset),
    .bus  (if64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          w64;
    int          len;
    logic [63:0] bytes;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [4];

  // ---------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout, expected DUT response (t=%0t)", name, $time);
  endtask

  function automatic int steps(input bit w);
    return w ? 8 : 4;
  endfunction

  function automatic logic get_ready(input bit w);
    return w ? if64.in_ready : if32.in_ready;
  endfunction

  function automatic logic get_busy(input bit w);
    return w ? if64.busy : if32.busy;
  endfunction

  function automatic logic get_hv(input bit w);
    return w ? if64.hash_valid : if32.hash_valid;
  endfunction

  function automatic logic [63:0] get_hash(input bit w);
    return w ? if64.hash_out : {32'h0, if32.hash_out};
  endfunction

  function automatic logic [63:0] pack_str(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  // Reference FNV-1a: hash = basis; for each byte: hash ^= b; hash *= prime.
  function automatic logic [63:0] fnv_model(input bit w, input logic [7:0] q[$]);
    logic [63:0] h;
    h = w ? 64'hcbf29ce484222325 : 64'h00000000811c9dc5;
    foreach (q[i]) begin
      h = h ^ {56'h0, q[i]};
      h = h * (w ? 64'h00000100000001b3 : 64'h0000000001000193);
      if (!w) h = h & 64'h00000000ffffffff;
    end
    return h;
  endfunction

  task automatic drive(input bit w, input bit v, input logic [7:0] d, input bit l, input bit c);
    if (w) begin
      if64.in_valid = v; if64.in_data = d; if64.in_last = l; if64.clear = c;
    end else begin
      if32.in_valid = v; if32.in_data = d; if32.in_last = l; if32.clear = c;
    end
  endtask

  // Called at a negedge. Offers a byte and returns at the negedge just after
  // the accepting edge; in_valid is left high so a following call behaves
  // like a continuously held stream.
  task automatic send_byte(input bit w, input logic [7:0] d, input bit l, output int acc_cycle);
    int n;
    n = 0;
    drive(w, 1'b1, d, l, 1'b0);
    while (!get_ready(w) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_timeout("accept_wait");
    @(negedge clk);
    acc_cycle = cyc;
  endtask

  // Counts negedges with in_ready low, starting at the accept negedge.
  task automatic measure(input bit w, output int lo);
    lo = 0;
    while (!get_ready(w) && lo < 50) begin
      lo++;
      @(negedge clk);
    end
    if (lo >= 50) fail_timeout("ready_return");
  endtask

  task automatic add_vec(input int i, input bit w, input string s, input logic [63:0] e);
    vecs[i].w64   = w;
    vecs[i].len   = s.len();
    vecs[i].bytes = pack_str(s);
    vecs[i].exp   = e;
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- test
  initial begin
    logic [63:0] prev_exp [2];
    bit          have_prev [2];
    int          ac, prev_ac, lo, s;
    bit          w;
    logic [7:0]  b;
    bit          lst;

    n_vec = 0;
    n_bad = 0;
    have_prev[0] = 1'b0;
    have_prev[1] = 1'b0;
    prev_ac = 0;

    add_vec(0, 1'b0, "a",      64'h00000000e40c292c);
    add_vec(1, 1'b0, "foobar", 64'h00000000bf9cf968);
    add_vec(2, 1'b1, "a",      64'haf63dc4c8601ec8c);
    add_vec(3, 1'b1, "foobar", 64'h85944171f73967e8);

    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    for (int wi = 0; wi < 2; wi++) begin
      check("reset_ready",      64'(get_ready(wi[0])), 64'd1);
      check("reset_busy",       64'(get_busy(wi[0])),  64'd0);
      check("reset_hash_valid", 64'(get_hv(wi[0])),    64'd0);
      check("reset_hash_out",   get_hash(wi[0]),       64'd0);
    end
    reset = 1'b0;
    @(negedge clk);

    // Known-answer table; messages on the same width run back-to-back.
    for (int i = 0; i < 4; i++) begin
      w = vecs[i].w64;
      s = steps(w);
      for (int j = 0; j < vecs[i].len; j++) begin
        b   = vecs[i].bytes[8*j +: 8];
        lst = (j == vecs[i].len - 1);
        send_byte(w, b, lst, ac);
        if (lst) drive(w, 1'b0, 8'h00, 1'b0, 1'b0);
        if (j > 0) check("accept_spacing", 64'(ac - prev_ac), 64'(s + 1));
        check("busy_at_accept", 64'(get_busy(w)), 64'd1);
        check("hv_low_in_msg",  64'(get_hv(w)),   64'd0);
        if (j == 0 && have_prev[w]) check("hash_out_held", get_hash(w), prev_exp[w]);
        prev_ac = ac;
        measure(w, lo);
        check("ready_low_cycles", 64'(lo), 64'(s));
      end
      check("kat_hash_valid", 64'(get_hv(w)), 64'd1);
      check("kat_hash_out",   get_hash(w),    vecs[i].exp);
      prev_exp[w]  = vecs[i].exp;
      have_prev[w] = 1'b1;
      $display("kat %0d: W=%0d len=%0d hash=%0h expect=%0h", i, w ? 64 : 32,
               vecs[i].len, get_hash(w), vecs[i].exp);
    end

    // Clear mid-multiply on the second byte of "foo", then "a".
    send_byte(1'b0, "f", 1'b0, ac);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    measure(1'b0, lo);
    send_byte(1'b0, "o", 1'b0, ac);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("clear_ready",      64'(get_ready(1'b0)), 64'd1);
    check("clear_busy",       64'(get_busy(1'b0)),  64'd0);
    check("clear_hash_valid", 64'(get_hv(1'b0)),    64'd0);
    check("clear_hash_out",   get_hash(1'b0),       64'h00000000bf9cf968);
    send_byte(1'b0, "a", 1'b1, ac);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("clear_hv_low", 64'(get_hv(1'b0)), 64'd0);
    measure(1'b0, lo);
    check("clear_then_a", get_hash(1'b0), 64'h00000000e40c292c);
    $display("clear seq: hash=%0h expect=e40c292c", get_hash(1'b0));

    // Asynchronous reset between clock edges during a multiply.
    send_byte(1'b0, "f", 1'b0, ac);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("areset_ready",      64'(get_ready(1'b0)), 64'd1);
    check("areset_busy",       64'(get_busy(1'b0)),  64'd0);
    check("areset_hash_valid", 64'(get_hv(1'b0)),    64'd0);
    check("areset_hash_out",   get_hash(1'b0),       64'd0);
    check("areset_hash_out64", get_hash(1'b1),       64'd0);
    @(negedge clk);
    @(negedge clk);
    #3;
    reset = 1'b0;
    @(negedge clk);
    send_byte(1'b0, "a", 1'b1, ac);
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    measure(1'b0, lo);
    check("areset_then_a", get_hash(1'b0), 64'h00000000e40c292c);
    $display("async reset seq: hash=%0h expect=e40c292c", get_hash(1'b0));

    // Random streams with gapped in_valid; even iterations pulse clear with
    // in_valid high while idle after the first byte.
    for (int it = 0; it < 20; it++) begin
      logic [7:0] m [8];
      logic [7:0] acc_q [$];
      int         len, idx, cnt, guard;
      bit         did_clear, done, got_last, v, clr;
      len = $urandom_range(1, 6);
      for (int j = 0; j < 8; j++) m[j] = 8'($urandom);
      acc_q.delete();
      idx = 0; cnt = 0; guard = 0;
      did_clear = 1'b0; done = 1'b0; got_last = 1'b0;
      while (!done && guard < 400) begin
        check("rand_ready", 64'(get_ready(1'b0)), 64'(cnt == 0));
        clr = (it % 2 == 0) && !did_clear && cnt == 0 && idx == 1;
        v   = clr ? 1'b1 : 1'($urandom_range(0, 1));
        drive(1'b0, v, m[idx], idx == len - 1, clr);
        @(negedge clk);
        guard++;
        if (clr) begin
          did_clear = 1'b1;
          acc_q.delete();
          idx = 0;
          cnt = 0;
        end else if (cnt == 0 && v) begin
          acc_q.push_back(m[idx]);
          if (idx == len - 1) got_last = 1'b1;
          idx++;
          cnt = steps(1'b0);
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0 && got_last) done = 1'b1;
        end
      end
      drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      if (!done) fail_timeout("rand_message");
      check("rand_hash_valid", 64'(get_hv(1'b0)), 64'd1);
      check("rand_hash_out",   get_hash(1'b0),    fnv_model(1'b0, acc_q));
      $display("rand %0d: len=%0d accepted=%0d clear=%0d hash=%0h model=%0h", it, len,
               acc_q.size(), did_clear, get_hash(1'b0), fnv_model(1'b0, acc_q));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
